qram_sdram_initiator: RTL and testbench
=======================================

QRAM_SDRAM_INITIATOR -- requirements
Module: qram_sdram_initiator

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the address bits serialized per access.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the data bits serialized per access.
REQ-003 The block SHALL have parameter READ_LATENCY, default 2, giving the cycles from a Read-qualified bit cycle to a valid outputQBit; legal range is 1..7.
REQ-004 DDRClockP  in  1  the single clock, rising edge only.
REQ-005 ResetN  in  1  asynchronous, active-low reset.
REQ-006 ReqValid  in  1  request present.
REQ-007 ReqReady  out  1  block idle and accepting a request.
REQ-008 ReqWrite  in  1  1 = write access, 0 = read access.
REQ-009 ReqAddress  in  ADDR_W  cell address.
REQ-010 ReqData  in  DATA_W  write data; ignored for reads.
REQ-011 RspValid  out  1  read data available.
REQ-012 RspReady  in  1  consumer accepts the read data.
REQ-013 RspData  out  DATA_W  assembled read data.
REQ-014 AddressQBit  out  1  serial address bit to the QRAM cell array.
REQ-015 inputQBit  out  1  serial write-data bit to the QRAM.
REQ-016 Write  out  1  write qualifier to the QRAM.
REQ-017 Read  out  1  read qualifier to the QRAM.
REQ-018 outputQBit  in  1  serial read-data bit from the QRAM.

Function
REQ-019 The block SHALL be a registered FSM with states IDLE, ADDR, WDATA, RDATA and RESP; all outputs SHALL be driven from registers.
REQ-020 ReqReady SHALL be 1 exactly when the state is IDLE.
REQ-021 A request SHALL be accepted on a rising edge where ReqValid=1 and ReqReady=1; the accepted address, data and write flag SHALL be latched, and the state SHALL become ADDR.
REQ-022 ADDR SHALL last ADDR_W cycles and SHALL drive AddressQBit MSB first, one bit per cycle; Write and Read SHALL be 0 during ADDR.
REQ-023 After ADDR, the state SHALL move to WDATA if the latched write flag is 1, otherwise to RDATA.
REQ-024 WDATA SHALL last DATA_W cycles with Write=1 and inputQBit carrying the data MSB first, then return to IDLE.
REQ-025 A write SHALL produce no response.
REQ-026 RDATA SHALL last DATA_W+READ_LATENCY cycles.
REQ-027 During RDATA, Read SHALL be 1 for exactly the first DATA_W cycles.
REQ-028 outputQBit SHALL be sampled READ_LATENCY cycles after each Read cycle and shifted into RspData MSB first.
REQ-029 The sample timing SHALL be tracked by a READ_LATENCY-deep enable delay line.
REQ-030 After RDATA, the state SHALL move to RESP with RspValid=1.
REQ-031 In RESP, RspValid and RspData SHALL hold stable until a rising edge with RspReady=1, after which the state SHALL return to IDLE.
REQ-032 If RspReady is already 1 when RESP is entered, RESP SHALL last exactly 1 cycle.
REQ-033 Read and Write SHALL never both be 1 in the same cycle.
REQ-034 inputQBit SHALL be 0 outside WDATA, and AddressQBit SHALL be 0 outside ADDR.
REQ-035 ReqValid while busy SHALL be ignored, with no queuing.
REQ-036 A new request MAY be accepted on the first IDLE cycle after a write or read completes.
REQ-037 The bit counter SHALL be wide enough for max(ADDR_W, DATA_W+READ_LATENCY) and SHALL reset to 0 on every state entry.

Reset
REQ-038 ResetN=0 SHALL immediately, without waiting for a clock edge, force state IDLE, all counters and latched fields to 0, and all outputs to 0.
REQ-039 ReqReady SHALL be 0 while ResetN=0 and SHALL become 1 on the first rising edge after ResetN returns to 1.
REQ-040 A reset during ADDR, WDATA, RDATA or RESP SHALL abort the access, discard any partial read data and produce no RspValid.

Structure
REQ-041 A shared package qram_pkg SHALL hold the FSM state enumeration and the default ADDR_W, DATA_W and READ_LATENCY constants.
REQ-042 A single sub-module qram_sample_delay SHALL implement the READ_LATENCY-deep sample-enable shift register, clocked by DDRClockP and reset by ResetN.

Verification
REQ-043 Reset: drive ResetN=0 mid-RDATA -> Read, RspValid and ReqReady go to 0 asynchronously; after release, ReqReady=1 on the next edge and no RspValid ever appears.
REQ-044 Write A=0xA5, D=0x3C -> AddressQBit 1,0,1,0,0,1,0,1 over 8 cycles, then Write=1 for 8 cycles with inputQBit 0,0,1,1,1,1,0,0, then ReqReady=1, and RspValid stays 0 throughout.
REQ-045 Read A=0x0F with a bench QRAM model returning 0xC3 at latency 2 -> Read=1 for exactly 8 cycles, RspValid=1 with RspData=0xC3 on cycle 19 after accept.
REQ-046 Backpressure: RspReady held 0 for 5 cycles in RESP -> RspValid=1 and RspData=0xC3 stay stable and ReqReady=0 until RspReady=1, then IDLE follows.
REQ-047 ReqValid held high continuously with a write (0x01, 0xFF) then a read (0x01) -> second request is accepted only on the first IDLE cycle, and the read returns 0xFF.
REQ-048 Assertions: Read and Write are never both 1, and AddressQBit and inputQBit are 0 outside their active states, across all scenarios.

Source files
------------

// File: rtl/qram_pkg.sv
// qram_pkg -- shared FSM encoding and default geometry for the QRAM serial initiator.
// Rev 1.0
`default_nettype none

package qram_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Bits needed to count 0..max(a,b)-1 without overflow.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/qram_sample_delay.sv
// qram_sample_delay -- DEPTH-stage shift register delaying the Read qualifier into a sample enable.
// Rev 1.0
`default_nettype none

module qram_sample_delay
  import qram_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic DDRClockP,
  input  logic ResetN,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) stages <= '0;
        else         stages <= din;
      end
    end else begin : g_multi
      always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) stages <= '0;
        else         stages <= {stages[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = stages[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/qram_sdram_initiator.sv
// qram_sdram_initiator -- serialises one address/data access to a QRAM cell array per request.
// Rev 1.0
`default_nettype none

module qram_sdram_initiator
  import qram_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              DDRClockP,
  input  logic              ResetN,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              AddressQBit,
  output logic              inputQBit,
  output logic              Write,
  output logic              Read,
  input  logic              outputQBit
);

  localparam int               CNT_W      = cnt_width(ADDR_W, DATA_W + READ_LATENCY);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] WDATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] RDATA_LAST = CNT_W'(DATA_W + READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] DATA_CNT   = CNT_W'(DATA_W);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_sr, addr_sr_d;
  logic [DATA_W-1:0] data_sr, data_sr_d;
  logic              is_write, is_write_d;
  logic              sample_en;

  always_ff @(posedge DDRClockP or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      is_write    <= 1'b0;
      ReqReady    <= 1'b0;
      AddressQBit <= 1'b0;
      inputQBit   <= 1'b0;
      Write       <= 1'b0;
      Read        <= 1'b0;
      RspValid    <= 1'b0;
      RspData     <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr_sr  <= addr_sr_d;
      data_sr  <= data_sr_d;
      is_write <= is_write_d;
      // Outputs are decoded from the next state so they line up with the state they belong to.
      ReqReady    <= (state_d == IDLE);
      AddressQBit <= (state_d == ADDR) && addr_sr_d[ADDR_W-1];
      inputQBit   <= (state_d == WDATA) && data_sr_d[DATA_W-1];
      Write       <= (state_d == WDATA);
      Read        <= (state_d == RDATA) && (cnt_d < DATA_CNT);
      RspValid    <= (state_d == RESP);
      if (sample_en) RspData <= {RspData[DATA_W-2:0], outputQBit};
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + CNT_W'(1);
    addr_sr_d  = addr_sr;
    data_sr_d  = data_sr;
    is_write_d = is_write;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (ReqValid && ReqReady) begin
          state_d    = ADDR;
          addr_sr_d  = ReqAddress;
          data_sr_d  = ReqData;
          is_write_d = ReqWrite;
        end
      end
      ADDR: begin
        if (cnt == ADDR_LAST) begin
          state_d = is_write ? WDATA : RDATA;
          cnt_d   = '0;
        end else begin
          addr_sr_d = addr_sr << 1;
        end
      end
      WDATA: begin
        if (cnt == WDATA_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          data_sr_d = data_sr << 1;
        end
      end
      RDATA: begin
        if (cnt == RDATA_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (RspReady) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  qram_sample_delay #(
    .DEPTH(READ_LATENCY)
  ) u_sample_delay (
    .DDRClockP(DDRClockP),
    .ResetN   (ResetN),
    .din      (Read),
    .dout     (sample_en)
  );

endmodule

`default_nettype wire

// File: tb/tb_qram_sdram_initiator.sv
// tb_qram_sdram_initiator -- randomized self-checking bench with a behavioural QRAM and trace model.
// Rev 1.0
`default_nettype none

module tb_qram_sdram_initiator;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          ReqWrite = 1'b0;
  logic [AW-1:0] ReqAddress = '0;
  logic [DW-1:0] ReqData = '0;
  logic          RspValid;
  logic          RspReady = 1'b0;
  logic [DW-1:0] RspData;
  logic          AddressQBit;
  logic          inputQBit;
  logic          Write;
  logic          Read;
  logic          outputQBit = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] cur_rd_data = '0;
  logic [7:0]    hist = '0;
  int            bit_idx = 0;

  qram_sdram_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
  ) dut (
    .DDRClockP  (clk),
    .ResetN     (rst_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqAddress (ReqAddress),
    .ReqData    (ReqData),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .AddressQBit(AddressQBit),
    .inputQBit  (inputQBit),
    .Write      (Write),
    .Read       (Read),
    .outputQBit (outputQBit)
  );

  always #5 clk = ~clk;

  // QRAM: the bit for a Read cycle is presented RL cycles later; junk otherwise.
  always @(negedge clk) begin
    hist = {hist[6:0], Read};
    if (hist[RL]) begin
      outputQBit = cur_rd_data[DW-1-bit_idx];
      bit_idx++;
    end else begin
      outputQBit = 1'($urandom);
      bit_idx = 0;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (Read && Write) begin
      miscompares++;
      $display("FAIL rw_exclusive Read=%b Write=%b required not both 1", Read, Write);
    end
  end

  task automatic run_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int hold, input bit keep_valid, output int waited);
    int n_k;
    logic [5:0] exp, act;
    logic [DW-1:0] exp_rsp;
    ReqWrite = wr; ReqAddress = a; ReqData = d; ReqValid = 1'b1; RspReady = 1'b0;
    waited = 0;
    while (ReqReady !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout ReqReady=%b required 1", ReqReady);
      ReqValid = 1'b0;
      return;
    end
    exp_rsp = mem[a];
    if (wr) mem[a] = d;
    else    cur_rd_data = exp_rsp;
    n_k = AW + DW + (wr ? 0 : RL);
    for (int k = 1; k <= n_k; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_valid) ReqValid = 1'b0;
      if (k <= AW)  exp = {1'b0, a[AW-k], 4'b0000};
      else if (wr)  exp = {2'b00, d[DW-(k-AW)], 1'b1, 2'b00};
      else          exp = {4'b0000, (k <= AW + DW), 1'b0};
      act = {ReqReady, AddressQBit, inputQBit, Write, Read, RspValid};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s k=%0d {rdy,aq,iq,wr,rd,rv}=%b required %b",
                 wr ? "write_trace" : "read_trace", k, act, exp);
      end
    end
    if (!wr) begin
      for (int i = 0; i <= hold; i++) begin
        @(negedge clk);
        vectors++;
        if (RspValid !== 1'b1 || RspData !== exp_rsp || ReqReady !== 1'b0 || Read !== 1'b0) begin
          miscompares++;
          $display("FAIL resp_hold i=%0d RspValid=%b RspData=%h ReqReady=%b required 1 %h 0",
                   i, RspValid, RspData, ReqReady, exp_rsp);
        end
        RspReady = (i == hold);
      end
    end
    @(negedge clk);
    RspReady = 1'b0;
    vectors++;
    if ({ReqReady, RspValid, Read, Write, AddressQBit, inputQBit} !== 6'b100000) begin
      miscompares++;
      $display("FAIL back_to_idle {rdy,rv,rd,wr,aq,iq}=%b required 100000",
               {ReqReady, RspValid, Read, Write, AddressQBit, inputQBit});
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    ReqValid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ReqReady, RspValid, Read, Write, AddressQBit, inputQBit, RspData} !== '0) begin
      miscompares++;
      $display("FAIL reset_state outputs=%b required all 0",
               {ReqReady, RspValid, Read, Write, AddressQBit, inputQBit, RspData});
    end
    ReqValid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ReqReady !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge ReqReady=%b required 0", ReqReady);
    end
    @(negedge clk);
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release ReqReady=%b required 1", ReqReady);
    end
  endtask

  task automatic test_write;
    int w;
    run_access(1'b1, 8'hA5, 8'h3C, 0, 1'b0, w);
  endtask

  task automatic test_read;
    int w;
    mem[8'h0F] = 8'hC3;
    run_access(1'b0, 8'h0F, 8'h00, 0, 1'b0, w);
  endtask

  task automatic test_backpressure;
    int w;
    run_access(1'b0, 8'h0F, 8'h00, 5, 1'b0, w);
  endtask

  task automatic test_back_to_back;
    int w;
    run_access(1'b1, 8'h01, 8'hFF, 0, 1'b1, w);
    run_access(1'b0, 8'h01, 8'h00, 0, 1'b0, w);
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL back_to_back_wait waited=%0d required 0", w);
    end
  endtask

  task automatic test_random;
    int w;
    for (int n = 0; n < 24; n++) begin
      run_access(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                 $urandom_range(0, 3), (n != 23) && ($urandom_range(0, 1) == 1), w);
    end
    ReqValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int waited = 0;
    ReqWrite = 1'b0; ReqAddress = 8'h33; ReqValid = 1'b1; RspReady = 1'b0;
    cur_rd_data = mem[8'h33];
    while (ReqReady !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    repeat (AW + 3) @(negedge clk);
    ReqValid = 1'b0;
    vectors++;
    if (Read !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_read_active Read=%b required 1", Read);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({Read, RspValid, ReqReady, RspData} !== '0) begin
      miscompares++;
      $display("FAIL async_reset {rd,rv,rdy,data}=%b required all 0", {Read, RspValid, ReqReady, RspData});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    RspReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (ReqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_abort ReqReady=%b required 1", ReqReady);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      vectors++;
      if (RspValid !== 1'b0 || Read !== 1'b0) begin
        miscompares++;
        $display("FAIL no_rsp_after_abort cycle=%0d RspValid=%b Read=%b required 0 0", i, RspValid, Read);
      end
    end
    RspReady = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
